// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: sequential imem requests, prefetch FIFO,
// and redirect handling that flushes buffered entries and drops stale responses.
module fetch_unit #(
    parameter int ADDR_W   = 32,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_OUT  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     imem_req_valid,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [INSTR_W-1:0]       imem_rsp_data,
    output logic                     out_valid,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [ADDR_W-1:0]        out_pc4,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IF_W  = $clog2(MAX_OUT + 1);
    localparam int SUM_W = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic [IF_W-1:0]    inflight_q, inflight_d;
    logic [IF_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem [DEPTH];

    logic [SUM_W-1:0]   committed;
    logic               req_fire;
    logic               rsp_drop;
    logic               push;
    logic               pop;

    // Every transfer on either side happens on a rising edge where valid && ready;
    // a request is only raised when a FIFO slot is already reserved for its response.
    always_comb begin
        committed = SUM_W'(count_q) + SUM_W'(inflight_q - drop_cnt_q);
    end

    assign imem_req_valid = rst_n && !redirect_valid
                            && (inflight_q < IF_W'(MAX_OUT))
                            && (committed < SUM_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
    assign push           = imem_rsp_valid && !rsp_drop && !redirect_valid;

    assign out_valid = (count_q != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_instr = instr_mem[rd_ptr_q];
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_pc4   = out_pc + ADDR_W'(4);
    assign occupancy = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            // Everything still outstanding after this cycle is stale.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            inflight_d = inflight_q - IF_W'(imem_rsp_valid);
            drop_cnt_d = inflight_q - IF_W'(imem_rsp_valid);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            inflight_d = inflight_q + IF_W'(req_fire) - IF_W'(imem_rsp_valid);
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + ADDR_W'(4);
                wr_ptr_d  = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count_q != CNT_W'(DEPTH)));
    a_drop_le_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt_q <= inflight_q);
    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order variable-latency imem model plus a
// scoreboard of expected output PCs popped by a monitor on each output handshake.
module tb_fetch_unit;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_ready = 1'b1;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .out_ready      (out_ready),
        .occupancy      (occupancy)
    );

    int errors = 0;
    int checks = 0;
    int popped = 0;
    int lat = 1;
    int cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] addr_q[$];
    int          due_q[$];
    logic [31:0] exp_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a << 12) ^ a ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        acc_q.delete();
        popped = 0;
        rst_n = 1'b1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic end_window(input string name, input int n, input bit exact);
        out_ready = 1'b0;
        checks++;
        if (exact ? (popped != n) : (popped < n)) begin
            errors++;
            $display("FAIL %s_outputs: got %0d outputs, required %s%0d",
                     name, popped, exact ? "" : "at least ", n);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 32'hDEAD_DEAD;
    endfunction

    // Memory model: record accepted requests, answer each exactly lat cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            due_q.delete();
            addr_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            due_q.push_back(cyc + lat);
            addr_q.push_back(imem_req_addr);
            acc_q.push_back(imem_req_addr);
        end
    end

    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (rst_n && due_q.size() > 0 && due_q[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(addr_q[0]);
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            popped++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc %h, required no output", out_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                chk("out_pc", out_pc, exp_pc);
                chk("out_pc4", out_pc4, exp_pc + 32'd4);
                chk("out_instr", out_instr, instr_of(exp_pc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values and steady one-per-cycle stream, L = 1.
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        tick(); #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        do_reset();
        push_seq(RESET_PC, 8);
        #1;
        chk("a_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("a_first_req_addr", imem_req_addr, RESET_PC);
        tick(); #1;
        chk("a_cycle1_out_valid", 32'(out_valid), 32'd0);
        tick(); #1;
        chk("a_cycle2_out_valid", 32'(out_valid), 32'd1);
        repeat (8) tick();
        end_window("a_steady", 8, 1'b1);

        // Consumer stalled: exactly DEPTH requests, then drain and resume at 0x110.
        out_ready = 1'b0;
        do_reset();
        repeat (8) tick();
        #1;
        chk("b_req_valid_full", 32'(imem_req_valid), 32'd0);
        chk("b_occupancy_full", 32'(occupancy), 32'd4);
        chk("b_req_count", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("b_req_addr", acc_at(i), RESET_PC + 32'(4 * i));
        push_seq(RESET_PC, 8);
        out_ready = 1'b1;
        repeat (8) tick();
        end_window("b_drain", 8, 1'b1);
        chk("b_resume_addr", acc_at(4), 32'h0000_0110);

        // Redirect with three requests outstanding and none returning that cycle.
        lat = 4; out_ready = 1'b1;
        do_reset();
        push_seq(32'h0000_0400, 16);
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        #1;
        chk("c_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        chk("c_redirect_out_valid", 32'(out_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("c_drop_cnt_3", 32'(dut.drop_cnt_q), 32'd3);
        chk("c_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c_req_addr", imem_req_addr, 32'h0000_0400);
        tick(); #1;
        chk("c_drop_cnt_2", 32'(dut.drop_cnt_q), 32'd2);
        tick(); #1;
        chk("c_drop_cnt_1", 32'(dut.drop_cnt_q), 32'd1);
        tick(); #1;
        chk("c_drop_cnt_0", 32'(dut.drop_cnt_q), 32'd0);
        repeat (13) tick();
        end_window("c_redirect", 6, 1'b0);
        chk("c_accepted_after_redirect", acc_at(3), 32'h0000_0400);

        // Redirect in the same cycle as a response, two requests outstanding.
        lat = 2; out_ready = 1'b1;
        do_reset();
        push_seq(32'h0000_0300, 16);
        repeat (2) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        #1;
        chk("d_rsp_in_redirect_cycle", 32'(imem_rsp_valid), 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("d_drop_cnt_1", 32'(dut.drop_cnt_q), 32'd1);
        chk("d_req_addr", imem_req_addr, 32'h0000_0300);
        tick(); #1;
        chk("d_drop_cnt_0", 32'(dut.drop_cnt_q), 32'd0);
        repeat (10) tick();
        end_window("d_same_cycle", 6, 1'b0);

        // Memory stalled: address holds, redirect during the stall takes effect next cycle.
        lat = 1; out_ready = 1'b1; imem_req_ready = 1'b0;
        do_reset();
        push_seq(32'h0000_0200, 16);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("e_stall_req_valid", 32'(imem_req_valid), 32'd1);
            chk("e_stall_req_addr", imem_req_addr, RESET_PC);
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        chk("e_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
        chk("e_new_req_valid", 32'(imem_req_valid), 32'd1);
        chk("e_new_req_addr", imem_req_addr, 32'h0000_0200);
        repeat (10) tick();
        end_window("e_stall", 6, 1'b0);

        // Asynchronous reset mid-stream with three buffered entries.
        lat = 1; out_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        #1;
        chk("f_occupancy_3", 32'(occupancy), 32'd3);
        chk("f_out_valid_before", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("f_async_occupancy", 32'(occupancy), 32'd0);
        chk("f_async_out_valid", 32'(out_valid), 32'd0);
        chk("f_async_req_valid", 32'(imem_req_valid), 32'd0);
        do_reset();
        out_ready = 1'b1;
        push_seq(RESET_PC, 8);
        #1;
        chk("f_restart_addr", imem_req_addr, RESET_PC);
        repeat (10) tick();
        end_window("f_restart", 8, 1'b1);

        // PC wrap at the top of the address space, including out_pc4.
        lat = 1; out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        #1;
        chk("g_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        push_seq(32'hFFFF_FFF8, 6);
        repeat (8) tick();
        end_window("g_wrap", 6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
